// File: rtl/mem_pkg.sv
// Package: mem_pkg
// Shared definitions for the data-memory access controller.
//   - size codes for load/store requests (byte, half, word, illegal)
//   - controller FSM state encoding
//   - req_is_bad(): legality / alignment check for a request
//   - lane_mask(): which byte lanes of the write data a store uses
package mem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // A request is rejected when its size code is illegal or its address is
  // not naturally aligned for the access size.
  function automatic logic req_is_bad(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    return (size == SZ_ILL)
        || ((size == SZ_H) && addr_lo[0])
        || ((size == SZ_W) && (addr_lo != 2'b00));
  endfunction

  // Byte lanes carried by a store of the given size; other lanes go out as 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Module: load_extend
// Combinational load-data formatter. Selects the low byte, low half or full
// word of the raw memory data and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata       in  32  raw data from the memory (addressed byte in [7:0])
//   size        in  2   access size code (SZ_B / SZ_H / SZ_W)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended load value
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic byte_fill;
  logic half_fill;

  // Fill bit for the upper bits: zero for unsigned, the top data bit otherwise.
  assign byte_fill = ~is_unsigned & rdata[7];
  assign half_fill = ~is_unsigned & rdata[15];

  always_comb begin
    result = rdata;
    case (size)
      SZ_B:    result = {{24{byte_fill}}, rdata[7:0]};
      SZ_H:    result = {{16{half_fill}}, rdata[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Module: mem_access_ctrl
// Requester-side controller for the byte-addressed data BRAM. Takes one
// load/store at a time, drives the BRAM port for a single cycle, extends load
// data, and returns every request through a valid/ready response. Misaligned
// or illegal-size requests are answered with resp_err and never reach memory.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                request fields
//   resp_valid / resp_ready  response handshake (valid held until ready)
//   resp_rdata, resp_err     response payload
//   mem_wen, mem_b, mem_h,
//   mem_u, mem_addr,
//   mem_wdata                registered BRAM port drive
//   mem_rdata                BRAM read data (one cycle after the address)
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_wen,
  output logic              mem_b,
  output logic              mem_h,
  output logic              mem_u,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LANES = DATA_W / 8;

  state_t state_reg, state_next;

  // Request fields still needed after the accept cycle.
  logic       we_reg,   we_next;
  logic [1:0] size_reg, size_next;
  logic       uns_reg,  uns_next;

  logic              resp_valid_next;
  logic [DATA_W-1:0] resp_rdata_next;
  logic              resp_err_next;
  logic              mem_wen_next;
  logic              mem_b_next;
  logic              mem_h_next;
  logic              mem_u_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;

  logic [LANES-1:0]  lane_en;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] ext_data;
  logic              req_bad;

  assign req_ready = (state_reg == ST_IDLE);
  assign req_bad   = req_is_bad(req_size, req_addr[1:0]);
  assign lane_en   = lane_mask(req_size);

  // Store data keeps only the lanes the access size writes; the rest are 0.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign wdata_lanes[8*gi +: 8] = lane_en[gi] ? req_wdata[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // mem_rdata is valid during CAPTURE, where size_reg/uns_reg still hold the
  // request's attributes.
  load_extend u_load_extend (
    .rdata       (mem_rdata),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .result      (ext_data)
  );

  always_comb begin
    state_next      = state_reg;
    we_next         = we_reg;
    size_next       = size_reg;
    uns_next        = uns_reg;
    resp_valid_next = resp_valid;
    resp_rdata_next = resp_rdata;
    resp_err_next   = resp_err;
    // Write enable defaults low so it can only be high for the ACCESS cycle.
    mem_wen_next    = 1'b0;
    mem_b_next      = mem_b;
    mem_h_next      = mem_h;
    mem_u_next      = mem_u;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          we_next   = req_we;
          size_next = req_size;
          uns_next  = req_unsigned;
          if (req_bad) begin
            state_next      = ST_RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
          end else begin
            // Memory port is loaded here so it is presented during ACCESS.
            state_next     = ST_ACCESS;
            mem_addr_next  = req_addr;
            mem_b_next     = (req_size == SZ_B);
            mem_h_next     = (req_size == SZ_H);
            mem_u_next     = req_unsigned;
            mem_wen_next   = req_we;
            mem_wdata_next = req_we ? wdata_lanes : '0;
          end
        end
      end

      ST_ACCESS: begin
        if (we_reg) begin
          // The write commits on this edge, so the response can follow.
          state_next      = ST_RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b0;
          resp_rdata_next = '0;
        end else begin
          state_next = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        state_next      = ST_RESP;
        resp_valid_next = 1'b1;
        resp_err_next   = 1'b0;
        resp_rdata_next = ext_data;
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_next      = ST_IDLE;
          resp_valid_next = 1'b0;
          resp_err_next   = 1'b0;
          resp_rdata_next = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      we_reg     <= 1'b0;
      size_reg   <= SZ_B;
      uns_reg    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_wen    <= 1'b0;
      mem_b      <= 1'b0;
      mem_h      <= 1'b0;
      mem_u      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_reg  <= state_next;
      we_reg     <= we_next;
      size_reg   <= size_next;
      uns_reg    <= uns_next;
      resp_valid <= resp_valid_next;
      resp_rdata <= resp_rdata_next;
      resp_err   <= resp_err_next;
      mem_wen    <= mem_wen_next;
      mem_b      <= mem_b_next;
      mem_h      <= mem_h_next;
      mem_u      <= mem_u_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
    end
  end

endmodule
